// File: rtl/gate_in_pkg.sv
// Shared types and board constants for the gate input conditioner.
package gate_in_pkg;

    typedef enum logic {
        STABLE  = 1'b0,
        CONFIRM = 1'b1
    } ch_state_t;

    localparam int CLK_HZ              = 27000000;
    localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 50;
    localparam int LONG_CYCLES_DEF     = CLK_HZ;

endpackage

// File: rtl/gate_input_conditioner_debounce_ch.sv
// One debounce channel: two-flop synchroniser, STABLE/CONFIRM FSM with a
// persistence counter, registered clean level and rise/fall pulses.
module debounce_ch
    import gate_in_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int   CNT_W           = 20,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    ch_state_t        state, next_state;
    logic             sync1, sync2;
    logic             differ, accept;
    logic [CNT_W-1:0] count, count_next;

    assign differ = (sync2 != clean);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STABLE;
            count <= '0;
            clean <= RESET_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= next_state;
            count <= count_next;
            clean <= clean ^ accept;
            rise  <= accept & ~clean;
            fall  <= accept & clean;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            STABLE:  if (differ) next_state = CONFIRM;
            CONFIRM: if (!differ || count == LAST) next_state = STABLE;
        endcase
    end

    // Any sample agreeing with the held value drops the count to zero, so a
    // bounce restarts the whole window rather than pausing it.
    always_comb begin
        count_next = '0;
        accept     = 1'b0;
        case (state)
            STABLE: begin
                if (differ) count_next = CNT_W'(1);
            end
            CONFIRM: begin
                if (differ) begin
                    if (count == LAST) accept = 1'b1;
                    else               count_next = count + 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/gate_input_conditioner.sv
// Debounces the gate push button and slide switches for the controller FSM.
// Long-press pulse on key_long is built only when GATE_IN_LONG_PRESS_EN is defined.
module gate_input_conditioner
    import gate_in_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 20,
    parameter int N_SW            = 2,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter int LONG_W          = 25
) (
    input  logic            CLOCK_27,
    input  logic            RST_N,
    input  logic            KEY_RAW_N,
    input  logic [N_SW-1:0] SW_RAW,
    output logic            key_clean_n,
    output logic            key_press,
    output logic            key_release,
    output logic [N_SW-1:0] sw_clean,
    output logic [N_SW-1:0] sw_change,
    output logic            key_long
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << CNT_W) - 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES does not fit CNT_W");
    end
    if (LONG_CYCLES < 2 || LONG_CYCLES > (1 << LONG_W) - 1) begin : g_bad_long
        $error("LONG_CYCLES does not fit LONG_W");
    end

    logic [N_SW-1:0] sw_rise, sw_fall;

    // The button is active-low, so a falling clean level is a press.
    debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .RESET_VAL       (1'b1)
    ) u_key (
        .clk   (CLOCK_27),
        .rst_n (RST_N),
        .raw   (KEY_RAW_N),
        .clean (key_clean_n),
        .rise  (key_release),
        .fall  (key_press)
    );

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .RESET_VAL       (1'b0)
        ) u_sw (
            .clk   (CLOCK_27),
            .rst_n (RST_N),
            .raw   (SW_RAW[i]),
            .clean (sw_clean[i]),
            .rise  (sw_rise[i]),
            .fall  (sw_fall[i])
        );
    end

    assign sw_change = sw_rise | sw_fall;

`ifdef GATE_IN_LONG_PRESS_EN
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);

    logic [LONG_W-1:0] long_cnt;

    // The press cycle itself counts as the first held cycle, so key_long
    // lands LONG_CYCLES cycles after key_press; saturation blocks repeats.
    always_ff @(posedge CLOCK_27 or negedge RST_N) begin
        if (!RST_N) begin
            long_cnt <= '0;
            key_long <= 1'b0;
        end else begin
            key_long <= 1'b0;
            if (key_press) begin
                long_cnt <= LONG_W'(1);
            end else if (!key_clean_n) begin
                if (long_cnt != LONG_MAX) long_cnt <= long_cnt + 1'b1;
                if (long_cnt == LONG_LAST) key_long <= 1'b1;
            end else begin
                long_cnt <= '0;
            end
        end
    end
`else
    assign key_long = 1'b0;
`endif

endmodule

// File: tb/tb_gate_input_conditioner.sv
// Directed bench for gate_input_conditioner with a run-length reference model.
module tb_gate_input_conditioner;

    localparam int D    = 4;
    localparam int LONG = 10;
`ifdef GATE_IN_LONG_PRESS_EN
    localparam logic LONG_ON = 1'b1;
`else
    localparam logic LONG_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_raw_n = 1'b1;
    logic [1:0] sw_raw = 2'b00;
    logic       key_clean_n, key_press, key_release, key_long;
    logic [1:0] sw_clean, sw_change;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    gate_input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (20),
        .N_SW            (2),
        .LONG_CYCLES     (LONG),
        .LONG_W          (25)
    ) dut (
        .CLOCK_27    (clk),
        .RST_N       (rst_n),
        .KEY_RAW_N   (key_raw_n),
        .SW_RAW      (sw_raw),
        .key_clean_n (key_clean_n),
        .key_press   (key_press),
        .key_release (key_release),
        .sw_clean    (sw_clean),
        .sw_change   (sw_change),
        .key_long    (key_long)
    );

    always #5 clk = ~clk;

    // Reference model: bit 0 is the key, bits 2:1 the switches. A raw value
    // reaches the decision two edges after sampling; a channel flips once D
    // consecutive delayed samples disagree with its held level.
    logic [2:0] rawq[$];
    logic [2:0] held, pulse;
    int         run[3];
    int         age;

    task automatic resetModel();
        rawq.delete();
        rawq.push_back(3'b001);
        rawq.push_back(3'b001);
        held  = 3'b001;
        pulse = 3'b000;
        foreach (run[c]) run[c] = 0;
        age = -1;
    endtask

    task automatic stepModel();
        logic [2:0] dl;
        rawq.push_back({sw_raw, key_raw_n});
        dl = rawq.pop_front();
        for (int c = 0; c < 3; c++) begin
            pulse[c] = 1'b0;
            if (dl[c] != held[c]) begin
                run[c]++;
                if (run[c] == D) begin
                    held[c]  = ~held[c];
                    run[c]   = 0;
                    pulse[c] = 1'b1;
                end
            end else begin
                run[c] = 0;
            end
        end
        if (pulse[0] && !held[0])  age = 0;
        else if (held[0])          age = -1;
        else if (age >= 0)         age++;
    endtask

    initial begin
        resetModel();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) resetModel();
            else        stepModel();
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic [7:0] act, exp;
        logic       long_exp;
        @(negedge clk);
        cyc++;
        long_exp = LONG_ON && !held[0] && (age == LONG);
        exp = {held[0], pulse[0] & ~held[0], pulse[0] & held[0], held[2:1], pulse[2:1], long_exp};
        act = {key_clean_n, key_press, key_release, sw_clean, sw_change, key_long};
        checkOutput($sformatf("model cycle %0d", cyc), act, exp);
    endtask

    task automatic runCycles(input int n);
        repeat (n) tick();
    endtask

    task automatic applyStimulus(input logic key, input logic [1:0] sw);
        key_raw_n = key;
        sw_raw    = sw;
    endtask

    initial begin
        runCycles(3);
        checkOutput("reset key_clean_n", key_clean_n, 8'd1);
        checkOutput("reset sw_clean", sw_clean, 8'd0);
        checkOutput("reset pulses", {key_press, key_release, sw_change, key_long}, 8'd0);
        rst_n = 1'b1;
        runCycles(2);

        // Clean press, then a long hold and release
        applyStimulus(1'b0, 2'b00);
        runCycles(5);
        checkOutput("press before latency", key_clean_n, 8'd1);
        runCycles(1);
        checkOutput("press accepted", {key_clean_n, key_press, key_release}, 8'b010);
        runCycles(1);
        checkOutput("press pulse one cycle", key_press, 8'd0);
        runCycles(8);
        checkOutput("long before time", key_long, 8'd0);
        runCycles(1);
        checkOutput("long pulse", key_long, {7'd0, LONG_ON});
        runCycles(1);
        checkOutput("long single", key_long, 8'd0);
        runCycles(6);
        applyStimulus(1'b1, 2'b00);
        runCycles(6);
        checkOutput("release accepted", {key_clean_n, key_press, key_release}, 8'b101);
        runCycles(2);

        // Three-cycle glitch is rejected
        applyStimulus(1'b0, 2'b00);
        runCycles(3);
        applyStimulus(1'b1, 2'b00);
        runCycles(8);
        checkOutput("glitch rejected", key_clean_n, 8'd1);

        // Four-cycle burst is just long enough
        applyStimulus(1'b0, 2'b00);
        runCycles(4);
        applyStimulus(1'b1, 2'b00);
        runCycles(2);
        checkOutput("min burst press", {key_clean_n, key_press}, 8'b01);
        runCycles(3);
        checkOutput("min burst held", key_clean_n, 8'd0);
        runCycles(1);
        checkOutput("min burst release", {key_clean_n, key_release}, 8'b11);
        runCycles(2);

        // Switch 0 bounces before settling high
        applyStimulus(1'b1, 2'b01);
        runCycles(1);
        applyStimulus(1'b1, 2'b00);
        runCycles(1);
        applyStimulus(1'b1, 2'b01);
        runCycles(5);
        checkOutput("bounce not yet", sw_clean, 8'd0);
        runCycles(1);
        checkOutput("bounce accepted", {sw_clean, sw_change}, 8'b0101);
        runCycles(1);
        checkOutput("bounce pulse one cycle", sw_change, 8'd0);
        runCycles(2);
        applyStimulus(1'b1, 2'b00);
        runCycles(8);

        // All three channels accepted together
        applyStimulus(1'b0, 2'b11);
        runCycles(5);
        checkOutput("simul not yet", {key_clean_n, sw_clean}, 8'b100);
        runCycles(1);
        checkOutput("simul accepted", {key_clean_n, key_press, sw_clean, sw_change}, 8'b011111);
        runCycles(2);

        // Reset lands mid-window
        applyStimulus(1'b1, 2'b11);
        runCycles(4);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset key", key_clean_n, 8'd1);
        checkOutput("async reset sw", sw_clean, 8'd0);
        checkOutput("async reset pulses", {key_press, key_release, sw_change, key_long}, 8'd0);
        runCycles(2);
        rst_n = 1'b1;
        runCycles(5);
        checkOutput("post reset not yet", {key_clean_n, sw_clean}, 8'b100);
        runCycles(1);
        checkOutput("post reset accepted", {key_clean_n, key_release, sw_clean, sw_change}, 8'b101111);
        runCycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
